// File: rtl/add_seq_pkg.sv
// Shared definitions for the wide_add_sequencer: controller states and the
// width helper for the slice counter.
package add_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n_slices);
        return (n_slices <= 1) ? 1 : $clog2(n_slices);
    endfunction

endpackage

// File: rtl/cla_Nbit.sv
// Combinational N-bit carry-lookahead adder: every carry is expanded directly
// from the generate/propagate terms and the carry-in.
module cla_Nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         Cin,
    output logic [N-1:0] s,
    output logic         Cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         term;

    assign g = x & y;
    assign p = x ^ y;

    // c[i] = Cin&p[0..i-1]  |  OR_j g[j]&p[j+1..i-1]
    always_comb begin
        // NOTE: every variable written here gets a value first, so no path leaves it holding state (no latch).
        c    = '0;
        term = 1'b0;
        c[0] = Cin;
        for (int i = 1; i <= N; i++) begin
            term = Cin;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
    end

    assign s    = p ^ c[N-1:0];
    assign Cout = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle N-bit adder: one shared W-bit CLA slice processes the operands
// LSB slice first, with the slice carry registered between cycles.
module wide_add_sequencer #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         Cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         Cout
);
    import add_seq_pkg::*;

    localparam int NS = N / W;
    localparam int CW = cnt_width(NS);

    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_check
        $error("wide_add_sequencer: N must be a multiple of W and 1 <= W <= N");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [N-1:0]  res_q, res_d;

    logic [W-1:0]   slice_s;
    logic           slice_cout;
    logic [N+W-1:0] res_cat;

    cla_Nbit #(.N(W)) u_slice (
        .x    (opa_q[W-1:0]),
        .y    (opb_q[W-1:0]),
        .Cin  (carry_q),
        .s    (slice_s),
        .Cout (slice_cout)
    );

    // New slice enters at the MSB end; works unchanged when W == N.
    assign res_cat = {slice_s, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = x;
                    opb_d   = y;
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> W;
                opb_d   = opb_q >> W;
                res_d   = res_cat[N+W-1:W];
                carry_d = slice_cout;
                if (cnt_q == CW'(NS - 1)) begin
                    cout_d  = slice_cout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand and result registers are ordinary flops, not memories, so they take the reset too; state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign s         = res_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomised checks of wide_add_sequencer in four (N,W)
// configurations: (64,16), (8,8), (32,8) and (16,1).
module tb_wide_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv [4];
    logic        orr[4];
    logic [63:0] xv [4];
    logic [63:0] yv [4];
    logic        cv [4];

    logic [63:0] s0;
    logic [7:0]  s1;
    logic [31:0] s2;
    logic [15:0] s3;
    logic co0, co1, co2, co3;
    logic ov0, ov1, ov2, ov3;
    logic ir0, ir1, ir2, ir3;

    int pass_cnt = 0;
    int total_cnt = 0;

    wide_add_sequencer #(.N(64), .W(16)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .x(xv[0]), .y(yv[0]), .Cin(cv[0]),
        .out_valid(ov0), .out_ready(orr[0]), .s(s0), .Cout(co0));
    wide_add_sequencer #(.N(8), .W(8)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .x(xv[1][7:0]), .y(yv[1][7:0]), .Cin(cv[1]),
        .out_valid(ov1), .out_ready(orr[1]), .s(s1), .Cout(co1));
    wide_add_sequencer #(.N(32), .W(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .x(xv[2][31:0]), .y(yv[2][31:0]), .Cin(cv[2]),
        .out_valid(ov2), .out_ready(orr[2]), .s(s2), .Cout(co2));
    wide_add_sequencer #(.N(16), .W(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3),
        .x(xv[3][15:0]), .y(yv[3][15:0]), .Cin(cv[3]),
        .out_valid(ov3), .out_ready(orr[3]), .s(s3), .Cout(co3));

    // Combinational golden adder; narrower operands are zero-extended.
    logic [63:0] gx, gy, gs;
    logic        gc, gco;
    cla_Nbit #(.N(64)) u_gold (.x(gx), .y(gy), .Cin(gc), .s(gs), .Cout(gco));

    function automatic logic [63:0] get_s(input int d);
        case (d)
            0: return s0;
            1: return {56'b0, s1};
            2: return {32'b0, s2};
            default: return {48'b0, s3};
        endcase
    endfunction

    function automatic logic get_co(input int d);
        case (d)
            0: return co0;
            1: return co1;
            2: return co2;
            default: return co3;
        endcase
    endfunction

    function automatic logic get_ov(input int d);
        case (d)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            default: return ir3;
        endcase
    endfunction

    function automatic int nbits(input int d);
        case (d)
            0: return 64;
            1: return 8;
            2: return 32;
            default: return 16;
        endcase
    endfunction

    function automatic int nslices(input int d);
        case (d)
            0: return 4;
            1: return 1;
            2: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int d);
        logic [63:0] one;
        one = 64'd1;
        return (nbits(d) == 64) ? '1 : ((one << nbits(d)) - 64'd1);
    endfunction

    // Returns {Cout, s} packed with Cout at bit nbits(d).
    function automatic logic [64:0] ref_sum(input int d, input logic [63:0] a, input logic [63:0] b,
                                            input logic ci);
        logic [64:0] full, m;
        full = {1'b0, a} + {1'b0, b} + {64'b0, ci};
        m    = (nbits(d) == 64) ? '1 : ((65'd1 << (nbits(d) + 1)) - 65'd1);
        return full & m;
    endfunction

    function automatic logic [64:0] dut_sum(input int d);
        return ({64'b0, get_co(d)} << nbits(d)) | {1'b0, get_s(d)};
    endfunction

    // One full transaction. lat = edges from accept to out_valid; -1 if never accepted.
    task automatic do_op(input int d, input logic [63:0] a, input logic [63:0] b, input logic ci,
                         input int in_gap, input int out_gap, output logic [64:0] res, output int lat);
        int waited;
        res = '0;
        lat = -1;
        repeat (in_gap) begin
            @(posedge clk);
            #1;
        end
        waited = 0;
        while (!get_ir(d) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!get_ir(d)) return;
        xv[d] = a;
        yv[d] = b;
        cv[d] = ci;
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        xv[d] = ~a;
        yv[d] = {$urandom, $urandom};
        cv[d] = ~ci;
        lat = 0;
        while (!get_ov(d) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (out_gap) begin
            @(posedge clk);
            #1;
        end
        res = dut_sum(d);
        orr[d] = 1'b1;
        @(posedge clk);
        #1;
        orr[d] = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (s0 !== 64'd0) $display("FAIL reset_s got=%h exp=0", s0); else pass_cnt++;
        total_cnt++;
        if (co0 !== 1'b0) $display("FAIL reset_cout got=%b exp=0", co0); else pass_cnt++;
        total_cnt++;
        if (ov0 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ov0); else pass_cnt++;
        total_cnt++;
        if (ir0 !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", ir0); else pass_cnt++;
    endtask

    task automatic test_basic_add();
        logic [64:0] r;
        int lat;
        do_op(0, 64'd100000000, 64'd50000000, 1'b1, 0, 0, r, lat);
        total_cnt++;
        if (r[63:0] !== 64'd150000001) $display("FAIL basic_s got=%0d exp=150000001", r[63:0]); else pass_cnt++;
        total_cnt++;
        if (r[64] !== 1'b0) $display("FAIL basic_cout got=%b exp=0", r[64]); else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL basic_latency got=%0d exp=4", lat); else pass_cnt++;
    endtask

    task automatic test_carry_chain();
        logic [64:0] r;
        int lat;
        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1, 0, r, lat);
        total_cnt++;
        if (r[63:0] !== 64'd0) $display("FAIL carry_chain_s got=%h exp=0", r[63:0]); else pass_cnt++;
        total_cnt++;
        if (r[64] !== 1'b1) $display("FAIL carry_chain_cout got=%b exp=1", r[64]); else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL carry_chain_latency got=%0d exp=4", lat); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [64:0] r;
        int lat;
        xv[0] = 64'd5;
        yv[0] = 64'd7;
        cv[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 4) $display("FAIL bp_latency got=%0d exp=4", lat); else pass_cnt++;
        xv[0] = 64'd999;
        yv[0] = 64'd1000;
        cv[0] = 1'b1;
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (s0 !== 64'd12 || co0 !== 1'b0)
                $display("FAIL bp_hold_result cycle=%0d got=%0d/%b exp=12/0", i, s0, co0);
            else pass_cnt++;
            total_cnt++;
            if (ov0 !== 1'b1 || ir0 !== 1'b0)
                $display("FAIL bp_handshake cycle=%0d got ov=%b ir=%b exp ov=1 ir=0", i, ov0, ir0);
            else pass_cnt++;
        end
        orr[0] = 1'b1;
        @(posedge clk);
        #1;
        orr[0] = 1'b0;
        iv[0]  = 1'b0;
        total_cnt++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1)
            $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", ov0, ir0);
        else pass_cnt++;
        do_op(0, 64'd1, 64'd2, 1'b0, 0, 0, r, lat);
        total_cnt++;
        if (r !== 65'd3) $display("FAIL bp_next_op got=%0d exp=3", r); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [64:0] r;
        int lat;
        xv[0] = 64'h0001_0002_0003_0004;
        yv[0] = 64'h0010_0020_0030_0040;
        cv[0] = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1)
            $display("FAIL abort_handshake got ov=%b ir=%b exp ov=0 ir=1", ov0, ir0);
        else pass_cnt++;
        total_cnt++;
        if (s0 !== 64'd0) $display("FAIL abort_s got=%h exp=0", s0); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(0, 64'd12345, 64'd6789, 1'b0, 0, 0, r, lat);
        total_cnt++;
        if (r !== 65'd19134) $display("FAIL abort_next_op got=%0d exp=19134", r); else pass_cnt++;
    endtask

    task automatic test_single_slice();
        logic [64:0] r;
        int lat;
        do_op(1, 64'd100, 64'd50, 1'b0, 0, 0, r, lat);
        total_cnt++;
        if (r !== 65'd150) $display("FAIL n8_first got=%0d exp=150", r); else pass_cnt++;
        total_cnt++;
        if (lat !== 1) $display("FAIL n8_latency got=%0d exp=1", lat); else pass_cnt++;
        do_op(1, 64'd200, 64'd100, 1'b1, 0, 1, r, lat);
        total_cnt++;
        if (r[7:0] !== 8'd45 || r[8] !== 1'b1)
            $display("FAIL n8_wrap got s=%0d cout=%b exp s=45 cout=1", r[7:0], r[8]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int cfg[3] = '{0, 2, 3};
        logic [64:0] r, exp_r, gold_r;
        logic [63:0] a, b;
        logic ci;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            int d;
            d  = cfg[k % 3];
            a  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            b  = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            a  = a & mask_of(d);
            b  = b & mask_of(d);
            ci = 1'($urandom_range(0, 1));
            gx = a;
            gy = b;
            gc = ci;
            do_op(d, a, b, ci, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
            exp_r  = ref_sum(d, a, b, ci);
            gold_r = (nbits(d) == 64) ? {gco, gs} : {1'b0, gs};
            total_cnt++;
            if (r !== exp_r) $display("FAIL rand_arith n=%0d got=%h exp=%h", nbits(d), r, exp_r);
            else pass_cnt++;
            total_cnt++;
            if (r !== gold_r) $display("FAIL rand_golden n=%0d got=%h exp=%h", nbits(d), r, gold_r);
            else pass_cnt++;
            total_cnt++;
            if (lat !== nslices(d)) $display("FAIL rand_latency n=%0d got=%0d exp=%0d", nbits(d), lat, nslices(d));
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        gx = '0;
        gy = '0;
        gc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b0;
            xv[i]  = '0;
            yv[i]  = '0;
            cv[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
        test_single_slice();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
